// File: rtl/lora_rx_phase_cordic_if.sv
// Sample-in / phase-out bundle for the RX phase CORDIC.
// Handshake: a beat moves on a rising clk edge where valid && ready are both high;
// the producer holds valid and payload steady until then, and ready never waits on valid.
interface lora_rx_phase_cordic_if #(
  parameter int SAMPLE_W = 13,
  parameter int ANGLE_W  = 25
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [SAMPLE_W-1:0] i_in;
  logic signed [SAMPLE_W-1:0] q_in;
  logic                       out_valid;
  logic                       out_ready;
  logic [ANGLE_W-1:0]         angle_out;
  logic [SAMPLE_W:0]          mag_out;

  modport master (
    output in_valid, i_in, q_in, out_ready,
    input  in_ready, out_valid, angle_out, mag_out
  );

  modport slave (
    input  in_valid, i_in, q_in, out_ready,
    output in_ready, out_valid, angle_out, mag_out
  );
endinterface

// File: rtl/lora_rx_phase_cordic.sv
// Vectoring-mode CORDIC: one (I,Q) sample -> unsigned phase (full circle = 2^ANGLE_W)
// and gain-scaled magnitude, one micro-rotation per clock.
module lora_rx_phase_cordic #(
  parameter int SAMPLE_W   = 13,
  parameter int ANGLE_W    = 25,
  parameter int ITERATIONS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lora_rx_phase_cordic_if.slave bus,
  output logic [1:0]           dbg_state_o
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROTATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // Fractional guard bits below the sample LSB keep shift truncation from
  // eating the angle budget; the integer part is still SAMPLE_W+2 bits wide.
  localparam int GUARD = $clog2(ITERATIONS) + 2;
  localparam int XW    = SAMPLE_W + 2 + GUARD;
  localparam int KW    = $clog2(ITERATIONS);

  logic [1:0]           state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [XW-1:0] i_ext, q_ext, x_sh, y_sh;
  logic [ANGLE_W-1:0]   z_q, z_d, atan_k;
  logic                 null_vec;

  // atan(2^-k) on a 2^32 circle, rounded down to the ANGLE_W circle.
  function automatic logic [ANGLE_W-1:0] atan_lut(input logic [KW-1:0] k);
    logic [32:0] a32;
    logic [32:0] r;
    case (int'(k))
      0:  a32 = 33'd536870912;
      1:  a32 = 33'd316933406;
      2:  a32 = 33'd167458907;
      3:  a32 = 33'd85004756;
      4:  a32 = 33'd42667331;
      5:  a32 = 33'd21354465;
      6:  a32 = 33'd10679838;
      7:  a32 = 33'd5340245;
      8:  a32 = 33'd2670163;
      9:  a32 = 33'd1335087;
      10: a32 = 33'd667544;
      11: a32 = 33'd333772;
      12: a32 = 33'd166886;
      13: a32 = 33'd83443;
      14: a32 = 33'd41722;
      15: a32 = 33'd20861;
      16: a32 = 33'd10430;
      17: a32 = 33'd5215;
      18: a32 = 33'd2608;
      19: a32 = 33'd1304;
      20: a32 = 33'd652;
      21: a32 = 33'd326;
      22: a32 = 33'd163;
      23: a32 = 33'd81;
      24: a32 = 33'd41;
      25: a32 = 33'd20;
      26: a32 = 33'd10;
      27: a32 = 33'd5;
      28: a32 = 33'd3;
      29: a32 = 33'd1;
      default: a32 = 33'd0;
    endcase
    r = ((a32 << 1) >> (32 - ANGLE_W)) + 33'd1;
    r = r >> 1;
    return r[ANGLE_W-1:0];
  endfunction

  assign i_ext    = {{2{bus.i_in[SAMPLE_W-1]}}, bus.i_in, {GUARD{1'b0}}};
  assign q_ext    = {{2{bus.q_in[SAMPLE_W-1]}}, bus.q_in, {GUARD{1'b0}}};
  assign x_sh     = x_q >>> k_q;
  assign y_sh     = y_q >>> k_q;
  assign atan_k   = atan_lut(k_q);
  // A null vector has no direction to chase, so its phase stays where it started.
  assign null_vec = (x_q == '0) && (y_q == '0);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.i_in[SAMPLE_W-1]) begin
            x_d = -i_ext;
            y_d = -q_ext;
            z_d = {1'b1, {(ANGLE_W-1){1'b0}}};
          end else begin
            x_d = i_ext;
            y_d = q_ext;
            z_d = '0;
          end
          k_d     = '0;
          state_d = S_ROTATE;
        end
      end
      S_ROTATE: begin
        if (y_q[XW-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_k;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = null_vec ? z_q : z_q + atan_k;
        end
        k_d = k_q + 1'b1;
        if (k_q == KW'(ITERATIONS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.angle_out = z_q;
  assign bus.mag_out   = x_q[GUARD+SAMPLE_W:GUARD];
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_lora_rx_phase_cordic.sv
// Bench for lora_rx_phase_cordic: fixed vector table, handshake/reset sequences,
// and a random stream checked against a floating-point atan2/hypot model.
module tb_lora_rx_phase_cordic;
  localparam int  SW      = 13;
  localparam int  AW      = 25;
  localparam int  IT      = 16;
  localparam int  EW      = AW + SW + 1;
  localparam int  ANG_TOL = 1 << (AW - IT + 1);
  localparam real PI      = 3.14159265358979323846;

  typedef struct {
    int            i;
    int            q;
    logic [AW-1:0] ang;
    logic [SW:0]   mag;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    dbg_state;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            ready_mode = 0;
  real           k_gain;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  vec_t          vecs[10];

  lora_rx_phase_cordic_if #(.SAMPLE_W(SW), .ANGLE_W(AW)) bus();

  lora_rx_phase_cordic #(.SAMPLE_W(SW), .ANGLE_W(AW), .ITERATIONS(IT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk_eq(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endfunction

  function automatic void chk_tol(string name, longint act, longint req, longint tol, bit circ);
    longint m;
    longint d;
    m = longint'(1) << AW;
    d = act - req;
    if (circ) begin
      d = d % m;
      if (d < 0) d = d + m;
      if (d > m / 2) d = m - d;
    end else if (d < 0) begin
      d = -d;
    end
    n_cmp++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d +/- %0d", name, act, req, tol);
    end
  endfunction

  function automatic logic [EW-1:0] model(int i, int q);
    real    a;
    real    m;
    longint ai;
    longint mi;
    a = $atan2(real'(q), real'(i)) * real'(longint'(1) << AW) / (2.0 * PI);
    if (a < 0.0) a = a + real'(longint'(1) << AW);
    ai = longint'(a);
    if (ai >= (longint'(1) << AW)) ai = ai - (longint'(1) << AW);
    m  = k_gain * $sqrt(real'(i * i + q * q));
    mi = longint'(m);
    return {ai[AW-1:0], mi[SW:0]};
  endfunction

  // driver tasks
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input int i, input int q, input logic [EW-1:0] expv, input bit push,
                      output int acc);
    int budget;
    budget = 0;
    @(negedge clk);
    bus.i_in     = SW'(i);
    bus.q_in     = SW'(q);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    acc = cyc;
    if (!bus.in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 for 100 cycles, required 1");
    end else if (push) begin
      exp_q.push_back(expv);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < limit) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (25) @(negedge clk);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: angle %0d mag %0d, required no result",
                 bus.angle_out, bus.mag_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk_tol("angle", longint'(bus.angle_out), longint'(mon_e[EW-1:SW+1]), ANG_TOL, 1'b1);
        chk_tol("mag", longint'(bus.mag_out), longint'(mon_e[SW:0]),
                longint'(mon_e[SW:0]) / 100 + 2, 1'b0);
      end
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int            acc;
    int            acc2;
    int            budget;
    int            ri;
    int            rq;
    logic [EW-1:0] ev;

    bus.in_valid = 1'b0;
    bus.i_in     = '0;
    bus.q_in     = '0;
    k_gain = 1.0;
    for (int k = 0; k < IT; k++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2.0 * k));

    vecs[0] = '{4095, 0, 25'd0, 14'd6743};
    vecs[1] = '{0, 4095, 25'd8388608, 14'd6743};
    vecs[2] = '{-4095, 0, 25'd16777216, 14'd6743};
    vecs[3] = '{0, -4095, 25'd25165824, 14'd6743};
    vecs[4] = '{4095, -1, 25'd33553128, 14'd6743};
    vecs[5] = '{-4096, -4096, 25'd20971520, 14'd9539};
    vecs[6] = '{0, 0, 25'd0, 14'd0};
    vecs[7] = '{2896, 2896, 25'd4194304, 14'd6744};
    vecs[8] = '{-3000, 2000, 25'd13637074, 14'd5937};
    vecs[9] = '{1000, -3500, 25'd26652043, 14'd5994};

    // power-on reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("rst_in_ready_low", bus.in_ready, 0);
    chk_eq("rst_out_valid", bus.out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_in_ready", bus.in_ready, 1);
    chk_eq("post_rst_out_valid", bus.out_valid, 0);
    chk_eq("post_rst_angle", bus.angle_out, 0);
    chk_eq("post_rst_mag", bus.mag_out, 0);
    chk_eq("post_rst_state", dbg_state, 0);

    // vector table
    ready_mode = 0;
    for (int n = 0; n < 10; n++) send(vecs[n].i, vecs[n].q, {vecs[n].ang, vecs[n].mag}, 1'b1, acc);
    drain(400);

    // latency, stalled output and an ignored in_valid pulse
    ready_mode = 2;
    @(negedge clk);
    ev = model(2000, 1000);
    send(2000, 1000, ev, 1'b1, acc);
    budget = 0;
    while (!bus.out_valid && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    chk_eq("latency", cyc - acc, 17);
    for (int w = 0; w < 5; w++) begin
      chk_eq("stall_out_valid", bus.out_valid, 1);
      chk_eq("stall_in_ready", bus.in_ready, 0);
      chk_tol("stall_angle", longint'(bus.angle_out), longint'(ev[EW-1:SW+1]), ANG_TOL, 1'b1);
      if (w == 1) begin
        bus.i_in     = -13'sd1234;
        bus.q_in     = 13'sd567;
        bus.in_valid = 1'b1;
      end
      if (w == 2) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    ready_mode = 0;
    drain(100);

    // back-to-back throughput
    send(3000, 500, model(3000, 500), 1'b1, acc);
    send(-700, 3900, model(-700, 3900), 1'b1, acc2);
    chk_eq("throughput", acc2 - acc, 18);
    drain(100);

    // reset while rotating discards the sample
    send(1500, -2500, '0, 1'b0, acc);
    repeat (6) @(negedge clk);
    chk_eq("mid_rotate_state", dbg_state, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("mid_rst_out_valid", bus.out_valid, 0);
    chk_eq("mid_rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("after_mid_rst_in_ready", bus.in_ready, 1);
    chk_eq("after_mid_rst_out_valid", bus.out_valid, 0);
    chk_eq("after_mid_rst_angle", bus.angle_out, 0);
    chk_eq("after_mid_rst_mag", bus.mag_out, 0);
    repeat (30) @(negedge clk);

    // random full-scale stream with random back-pressure
    ready_mode = 1;
    for (int n = 0; n < 100; n++) begin
      do begin
        ri = int'($urandom_range(0, 8191)) - 4096;
        rq = int'($urandom_range(0, 8191)) - 4096;
      end while (ri > -1024 && ri < 1024 && rq > -1024 && rq < 1024);
      send(ri, rq, model(ri, rq), 1'b1, acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
